// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with a two-entry skid buffer (MAIN drives outputs, SKID absorbs
// one extra operation so in_ready can be a pure register), plus the architectural status flags.
module ex_mem_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] f_i,
    input  logic          z_i,
    input  logic          c_i,
    input  logic          v_i,
    input  logic          n_i,
    input  logic [DW-1:0] bd_i,
    input  logic [4:0]    da_i,
    input  logic          rw_i,
    input  logic          mw_i,
    input  logic          slt_i,
    input  logic          setf_i,
    input  logic [1:0]    md_i,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] f_o,
    output logic [DW-1:0] bd_o,
    output logic [4:0]    da_o,
    output logic [1:0]    md_o,
    output logic          rw_o,
    output logic          mw_o,
    output logic [3:0]    flags_o,
    output logic [3:0]    status_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DW-1:0] f;
        logic [DW-1:0] bd;
        logic [4:0]    da;
        logic [1:0]    md;
        logic          rw;
        logic          mw;
        logic [3:0]    flags;
    } payload_t;

    state_t   state_q, state_d;
    payload_t main_q, main_d;
    payload_t skid_q, skid_d;
    payload_t in_payload;
    logic [3:0] status_q, status_d;
    logic       accept;
    logic       pop;

    // The state encoding makes "SKID valid without MAIN" unrepresentable.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    always_comb begin
        in_payload.f     = slt_i ? {{(DW-1){1'b0}}, n_i ^ v_i} : f_i;
        in_payload.bd    = bd_i;
        in_payload.da    = da_i;
        in_payload.md    = md_i;
        in_payload.rw    = rw_i;
        in_payload.mw    = mw_i;
        in_payload.flags = {z_i, c_i, v_i, n_i};
    end

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        status_d = status_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            // Status commits on acceptance, not when the operation leaves.
            if (accept && setf_i) begin
                status_d = {z_i, c_i, v_i, n_i};
            end
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_payload;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_d = in_payload;
                    end else if (accept) begin
                        skid_d  = in_payload;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            status_q <= 4'b0000;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            status_q <= status_d;
        end
    end

    assign f_o      = main_q.f;
    assign bd_o     = main_q.bd;
    assign da_o     = main_q.da;
    assign md_o     = main_q.md;
    assign rw_o     = main_q.rw & out_valid;
    assign mw_o     = main_q.mw & out_valid;
    assign flags_o  = main_q.flags;
    assign status_o = status_q;

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter DW, default 32, datapath width of result and store data.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  execute stage presents a valid operation.
REQ-005 in_ready  out  1  stage can accept; transfer when in_valid & in_ready.
REQ-006 f_i  in  DW  function-unit result F.
REQ-007 z_i, c_i, v_i, n_i  in  1 each  function-unit flags Z, C, V, N.
REQ-008 bd_i  in  DW  store data (register B value).
REQ-009 da_i  in  5  destination register address.
REQ-010 rw_i, mw_i, slt_i, setf_i  in  1 each  register write, memory write, set-less-than, update-status.
REQ-011 md_i  in  2  writeback mux select, carried unchanged.
REQ-012 flush  in  1  discard all held and incoming operations.
REQ-013 out_valid  out  1  memory stage operation valid.
REQ-014 out_ready  in  1  memory stage accepts; transfer when out_valid & out_ready.
REQ-015 f_o, bd_o  out  DW  result and store data to memory stage.
REQ-016 da_o, md_o, rw_o, mw_o  out  5/2/1/1  carried controls.
REQ-017 flags_o  out  4  {Z,C,V,N} of the operation at the output.
REQ-018 status_o  out  4  architectural status register {Z,C,V,N}.

Function
REQ-019 Storage: two entries, MAIN (drives outputs) and SKID; each has a valid bit and full payload.
REQ-020 in_ready SHALL equal ~SKID.valid, registered (no combinational path from out_ready).
REQ-021 Accepted payload: if slt_i=1, f stored as {DW-1 zeros, n_i^v_i}, flags stored as-is; else f stored = f_i.
REQ-022 States: EMPTY (neither valid), ONE (MAIN valid only), FULL (both valid); SKID valid without MAIN SHALL never occur.
REQ-023 EMPTY + accept -> ONE, data into MAIN.
REQ-024 ONE + accept + out_ready -> ONE, MAIN replaced by new data; ONE + accept only -> FULL, data into SKID; ONE + out_ready only -> EMPTY.
REQ-025 FULL + out_ready -> ONE, SKID moved into MAIN same edge; no accept possible in FULL.
REQ-026 Latency: accepted operation appears at outputs one cycle after the accepting edge when EMPTY; order always preserved.
REQ-027 out_valid = MAIN.valid; payload outputs stable while out_valid & ~out_ready.
REQ-028 flush=1 at an edge: MAIN.valid and SKID.valid cleared, incoming transfer that cycle discarded, status_o unchanged by it; flush wins over all simultaneous events.
REQ-029 status_o updated at the edge an operation with setf_i=1 is accepted (not when it leaves), to that operation's {z_i,c_i,v_i,n_i}; setf_i=0 leaves it unchanged.
REQ-030 Payload registers of invalid entries hold last value; rw_o and mw_o SHALL be gated with out_valid (0 when out_valid=0).
REQ-031 No combinational path from in_valid/flush to in_ready.

Reset
REQ-032 rst_n low asynchronously forces: both valids 0, out_valid 0, in_ready 1 (after release, first edge), rw_o 0, mw_o 0, status_o 4'b0000, f_o/bd_o 0, da_o 0, md_o 0, flags_o 0.
REQ-033 Reset asserted mid-transfer discards all held operations; no partial state survives.

Verification
REQ-034 Stream: out_ready=1, three accepts f_i=1,2,3 on consecutive cycles -> f_o=1,2,3 on next three cycles, in_ready stays 1.
REQ-035 Backpressure: out_ready=0, accept A=0x10 then B=0x20 -> in_ready=0 after second accept, f_o holds 0x10; raise out_ready -> 0x10 then 0x20, in_ready returns 1.
REQ-036 SLT: slt_i=1, n_i=1, v_i=0, f_i=0xFFFFFFFE -> f_o=0x00000001; n_i=1, v_i=1 -> f_o=0.
REQ-037 Status: accept setf_i=1 with Z=1,C=0,V=0,N=0 then setf_i=0 with N=1 -> status_o=4'b1000 persists.
REQ-038 Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, rw_o=mw_o=0, status_o unchanged.
REQ-039 rst_n pulsed low mid-cycle while FULL -> outputs clear immediately without clock edge, per REQ-032.
